// File: rtl/itch_msg_parser.sv
// Purpose  : byte-serial ITCH 5.0 decoder; skips the MoldUDP64 header, walks length-prefixed
//            message blocks, decodes Add ('A'), Order Executed ('E') and Order Delete ('D').
// Latency  : decoded pulse and fields registered, valid 1 cycle after the final message byte strobe.
// Backpres.: none; every byte strobed by dataValidIn is consumed, idle cycles freeze the walker.
// Ports    : clkIn/rstIn (sync, active-low); dataValidIn/dataIn/dataLastIn byte stream in;
//            add/del/execValidOut pulses with refNumOut, locateOut, priceOut, sharesOut, buySellOut;
//            msgCountOut (decoded messages), errCountOut (truncations, plus length errors).
// Config   : define LEN_CHECK_EN to require exact block lengths (A=36, E=31, D=19); mismatching
//            blocks are skipped and counted as errors. Undefined: any length is decoded.
module itch_msg_parser #(
    parameter int HDR_BYTES = 20,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clkIn,
    input  logic                 rstIn,
    input  logic                 dataValidIn,
    input  logic [7:0]           dataIn,
    input  logic                 dataLastIn,
    output logic                 addValidOut,
    output logic                 delValidOut,
    output logic                 execValidOut,
    output logic [63:0]          refNumOut,
    output logic [15:0]          locateOut,
    output logic [31:0]          priceOut,
    output logic [31:0]          sharesOut,
    output logic                 buySellOut,
    output logic [CNT_WIDTH-1:0] msgCountOut,
    output logic [CNT_WIDTH-1:0] errCountOut
);

    typedef enum logic [2:0] {S_HDR, S_LEN_HI, S_LEN_LO, S_BODY, S_SKIP} state_t;

    state_t         r_state, w_state_nxt;
    logic [15:0]    r_cnt, w_cnt_nxt;       // header byte count in HDR, message offset in BODY/SKIP
    logic [15:0]    r_len, w_len_nxt;
    logic [7:0]     r_type;

    // staging copies of the fields of the message currently being walked
    logic [63:0]    r_s_ref, w_ref;
    logic [15:0]    r_s_loc, w_loc;
    logic [31:0]    r_s_price, w_price;
    logic [31:0]    r_s_shares, w_shares;
    logic           r_s_bs, w_bs;

    logic [7:0]     w_type;
    logic           w_is_a, w_is_d, w_is_e, w_sup, w_len_ok, w_final;
    logic           w_emit, w_trunc, w_len_err;

    logic           r_add, r_del, r_exec, r_bs;
    logic [63:0]    r_ref;
    logic [15:0]    r_loc;
    logic [31:0]    r_price, r_shares;
    logic [CNT_WIDTH-1:0] r_msg_cnt, r_err_cnt;

    // type byte is live on offset 0, registered afterwards
    assign w_type  = (r_cnt == 16'd0) ? dataIn : r_type;
    assign w_is_a  = (w_type == 8'h41);
    assign w_is_d  = (w_type == 8'h44);
    assign w_is_e  = (w_type == 8'h45);
    assign w_sup   = w_is_a | w_is_d | w_is_e;
    assign w_final = (r_cnt == r_len - 16'd1);

`ifdef LEN_CHECK_EN
    assign w_len_ok = (w_is_a && r_len == 16'd36) || (w_is_e && r_len == 16'd31) ||
                      (w_is_d && r_len == 16'd19);
`else
    assign w_len_ok = 1'b1;
`endif

    assign w_emit    = dataValidIn && (r_state == S_BODY) && w_final && w_sup && w_len_ok;
    // length error is flagged once, on the type byte
    assign w_len_err = dataValidIn && (r_state == S_BODY) && (r_cnt == 16'd0) && w_sup && !w_len_ok;
    // payload ended while a message (or its length prefix) was still open
    assign w_trunc   = dataValidIn && dataLastIn &&
                       ((r_state == S_LEN_HI) ||
                        ((r_state == S_LEN_LO) && ({r_len[15:8], dataIn} != 16'd0)) ||
                        (((r_state == S_BODY) || (r_state == S_SKIP)) && !w_final));

    // Field assembly: each byte lands in its big-endian slot, so bytes never received stay 0.
    always_comb begin
        w_ref    = (r_cnt == 16'd0) ? 64'd0 : r_s_ref;
        w_loc    = (r_cnt == 16'd0) ? 16'd0 : r_s_loc;
        w_price  = (r_cnt == 16'd0) ? 32'd0 : r_s_price;
        w_shares = (r_cnt == 16'd0) ? 32'd0 : r_s_shares;
        w_bs     = (r_cnt == 16'd0) ? 1'b0  : r_s_bs;
        for (int i = 0; i < 2; i++)
            if (r_cnt == 16'(1 + i)) w_loc[15 - 8*i -: 8] = dataIn;
        for (int i = 0; i < 8; i++)
            if (r_cnt == 16'(11 + i)) w_ref[63 - 8*i -: 8] = dataIn;
        if (w_is_a) begin
            if (r_cnt == 16'd19) w_bs = (dataIn == 8'h42);
            for (int i = 0; i < 4; i++) begin
                if (r_cnt == 16'(20 + i)) w_shares[31 - 8*i -: 8] = dataIn;
                if (r_cnt == 16'(32 + i)) w_price[31 - 8*i -: 8]  = dataIn;
            end
        end
        if (w_is_e) begin
            for (int i = 0; i < 4; i++)
                if (r_cnt == 16'(19 + i)) w_shares[31 - 8*i -: 8] = dataIn;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_len_nxt   = r_len;
        if (dataValidIn) begin
            case (r_state)
                S_HDR: begin
                    if (r_cnt == 16'(HDR_BYTES - 1)) begin
                        w_state_nxt = S_LEN_HI;
                        w_cnt_nxt   = 16'd0;
                    end else begin
                        w_cnt_nxt = r_cnt + 16'd1;
                    end
                end
                S_LEN_HI: begin
                    w_len_nxt   = {dataIn, r_len[7:0]};
                    w_state_nxt = S_LEN_LO;
                end
                S_LEN_LO: begin
                    w_len_nxt   = {r_len[15:8], dataIn};
                    w_cnt_nxt   = 16'd0;
                    w_state_nxt = ({r_len[15:8], dataIn} == 16'd0) ? S_LEN_HI : S_BODY;
                end
                S_BODY, S_SKIP: begin
                    if (w_final) begin
                        w_state_nxt = S_LEN_HI;
                        w_cnt_nxt   = 16'd0;
                    end else begin
                        if ((r_state == S_BODY) && (r_cnt == 16'd0) && !(w_sup && w_len_ok))
                            w_state_nxt = S_SKIP;
                        w_cnt_nxt = r_cnt + 16'd1;
                    end
                end
                default: w_state_nxt = S_HDR;
            endcase
            if (dataLastIn) begin
                w_state_nxt = S_HDR;
                w_cnt_nxt   = 16'd0;
            end
        end
    end

    always_ff @(posedge clkIn) begin
        if (!rstIn) begin
            r_state    <= S_HDR;
            r_cnt      <= 16'd0;
            r_len      <= 16'd0;
            r_type     <= 8'd0;
            r_s_ref    <= 64'd0;
            r_s_loc    <= 16'd0;
            r_s_price  <= 32'd0;
            r_s_shares <= 32'd0;
            r_s_bs     <= 1'b0;
            r_add      <= 1'b0;
            r_del      <= 1'b0;
            r_exec     <= 1'b0;
            r_ref      <= 64'd0;
            r_loc      <= 16'd0;
            r_price    <= 32'd0;
            r_shares   <= 32'd0;
            r_bs       <= 1'b0;
            r_msg_cnt  <= '0;
            r_err_cnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_len   <= w_len_nxt;
            r_add   <= w_emit && w_is_a;
            r_del   <= w_emit && w_is_d;
            r_exec  <= w_emit && w_is_e;
            if (dataValidIn && (r_state == S_BODY)) begin
                r_type     <= w_type;
                r_s_ref    <= w_ref;
                r_s_loc    <= w_loc;
                r_s_price  <= w_price;
                r_s_shares <= w_shares;
                r_s_bs     <= w_bs;
            end
            if (w_emit) begin
                r_ref     <= w_ref;
                r_loc     <= w_loc;
                r_price   <= w_is_a ? w_price : 32'd0;
                r_shares  <= w_is_d ? 32'd0 : w_shares;
                r_bs      <= w_is_a && w_bs;
                r_msg_cnt <= r_msg_cnt + CNT_WIDTH'(1);
            end
            if (w_trunc || w_len_err)
                r_err_cnt <= r_err_cnt + CNT_WIDTH'(1);
        end
    end

    assign addValidOut  = r_add;
    assign delValidOut  = r_del;
    assign execValidOut = r_exec;
    assign refNumOut    = r_ref;
    assign locateOut    = r_loc;
    assign priceOut     = r_price;
    assign sharesOut    = r_shares;
    assign buySellOut   = r_bs;
    assign msgCountOut  = r_msg_cnt;
    assign errCountOut  = r_err_cnt;

endmodule

// File: tb/tb_itch_msg_parser.sv
// Purpose  : self-checking bench for itch_msg_parser; table of messages plus hand-built corner cases.
// Latency  : checks each pulse lands exactly one cycle after the final byte strobe.
// Backpres.: none at the DUT; the driver may insert idle (dataValidIn=0) cycles between bytes.
module tb_itch_msg_parser;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rstn;
    logic          dv, dl;
    logic [7:0]    din;
    logic          add_o, del_o, exec_o, bs_o;
    logic [63:0]   ref_o;
    logic [15:0]   loc_o;
    logic [31:0]   price_o, shares_o;
    logic [CW-1:0] msgc_o, errc_o;

    always #5 clk = ~clk;

    itch_msg_parser #(.HDR_BYTES(20), .CNT_WIDTH(CW)) dut (
        .clkIn(clk), .rstIn(rstn), .dataValidIn(dv), .dataIn(din), .dataLastIn(dl),
        .addValidOut(add_o), .delValidOut(del_o), .execValidOut(exec_o),
        .refNumOut(ref_o), .locateOut(loc_o), .priceOut(price_o), .sharesOut(shares_o),
        .buySellOut(bs_o), .msgCountOut(msgc_o), .errCountOut(errc_o)
    );

    // kind is the expected pulse as {add, del, exec}; err is the expected error-count step
    typedef struct {
        logic [7:0]  typ;
        logic [15:0] len;
        logic [15:0] loc;
        logic [63:0] refn;
        logic [31:0] shares;
        logic [31:0] price;
        logic [7:0]  bsc;
        logic [2:0]  kind;
        int          err;
    } msg_t;

    typedef struct {
        logic [2:0]  kind;
        logic [63:0] refn;
        logic [15:0] loc;
        logic [31:0] price;
        logic [31:0] shares;
        logic        bs;
        int          cyc;
    } exp_t;

    msg_t tbl[10];
    exp_t q[$];
    int   n_cmp = 0, n_bad = 0, cyc = 0, n_push = 0, n_pop = 0, exp_err = 0;
    bit   idle_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic msg_t mk(input logic [7:0] typ, input logic [15:0] len, input logic [15:0] loc,
                                input logic [63:0] refn, input logic [31:0] shares,
                                input logic [31:0] price, input logic [7:0] bsc,
                                input logic [2:0] kind, input int err);
        msg_t m;
        m.typ = typ; m.len = len; m.loc = loc; m.refn = refn; m.shares = shares;
        m.price = price; m.bsc = bsc; m.kind = kind; m.err = err;
        return m;
    endfunction

    // wire image of one message byte; non-field bytes get a nonzero filler pattern
    function automatic logic [7:0] msg_byte(input msg_t m, input int off);
        logic [7:0] b;
        b = 8'(off * 7 + 3) ^ 8'hC3;
        if (off == 0)                          b = m.typ;
        else if (off <= 2)                     b = m.loc[8*(2-off) +: 8];
        else if (off >= 11 && off <= 18)       b = m.refn[8*(18-off) +: 8];
        else if (m.typ == 8'h41) begin
            if (off == 19)                     b = m.bsc;
            else if (off >= 20 && off <= 23)   b = m.shares[8*(23-off) +: 8];
            else if (off >= 32 && off <= 35)   b = m.price[8*(35-off) +: 8];
        end else if (m.typ == 8'h45 && off >= 19 && off <= 22)
                                               b = m.shares[8*(22-off) +: 8];
        return b;
    endfunction

    task automatic drive_byte(input logic [7:0] b, input logic last);
        if (idle_en && $urandom_range(0, 3) == 0) begin
            dv = 1'b0; din = 8'($urandom); dl = 1'b1;   // dataLastIn must be ignored when not strobed
            @(posedge clk); #1;
        end
        dv = 1'b1; din = b; dl = last;
        @(posedge clk); #1;
        dv = 1'b0; dl = 1'b0;
    endtask

    task automatic send_hdr();
        for (int i = 0; i < 20; i++) drive_byte(8'(i * 13 + 1), 1'b0);
    endtask

    // trunc_at >= 0: raise dataLastIn on that body offset and stop there
    task automatic send_msg(input msg_t m, input bit last, input int trunc_at);
        bit   lf;
        exp_t e;
        drive_byte(m.len[15:8], 1'b0);
        drive_byte(m.len[7:0], last && (m.len == 16'd0));
        for (int off = 0; off < int'(m.len); off++) begin
            lf = (off == trunc_at) || (last && off == int'(m.len) - 1);
            drive_byte(msg_byte(m, off), lf);
            if (off == trunc_at) break;
        end
        if (trunc_at >= 0) begin
            exp_err++;
        end else begin
            exp_err += m.err;
            if (m.kind != 3'b000) begin
                e.kind   = m.kind;
                e.refn   = m.refn;
                e.loc    = m.loc;
                e.price  = (m.typ == 8'h41) ? m.price : 32'd0;
                e.shares = (m.typ == 8'h44) ? 32'd0 : m.shares;
                e.bs     = (m.typ == 8'h41) && (m.bsc == 8'h42);
                e.cyc    = cyc;
                q.push_back(e);
                n_push++;
            end
        end
    endtask

    task automatic settle();
        dv = 1'b0; dl = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pending_pulses", 64'(q.size()), 64'd0);
        chk("msg_count", 64'(msgc_o), 64'(n_push));
        chk("err_count", 64'(errc_o), 64'(exp_err));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_add"}, 64'(add_o), 64'd0);
        chk({tag, "_del"}, 64'(del_o), 64'd0);
        chk({tag, "_exec"}, 64'(exec_o), 64'd0);
        chk({tag, "_ref"}, ref_o, 64'd0);
        chk({tag, "_loc"}, 64'(loc_o), 64'd0);
        chk({tag, "_price"}, 64'(price_o), 64'd0);
        chk({tag, "_shares"}, 64'(shares_o), 64'd0);
        chk({tag, "_bs"}, 64'(bs_o), 64'd0);
        chk({tag, "_msgc"}, 64'(msgc_o), 64'd0);
        chk({tag, "_errc"}, 64'(errc_o), 64'd0);
    endtask

    // scoreboard: every pulse must match the oldest expected message
    always @(negedge clk) begin : mon
        exp_t e;
        if (rstn === 1'b1 && (add_o || del_o || exec_o)) begin
            chk("onehot_pulse", 64'($countones({add_o, del_o, exec_o})), 64'd1);
            if (q.size() == 0) begin
                chk("spurious_pulse", 64'({add_o, del_o, exec_o}), 64'd0);
            end else begin
                e = q.pop_front();
                n_pop++;
                chk("pulse_kind", 64'({add_o, del_o, exec_o}), 64'(e.kind));
                chk("pulse_latency", 64'(cyc), 64'(e.cyc));
                chk("refnum", ref_o, e.refn);
                chk("locate", 64'(loc_o), 64'(e.loc));
                chk("price", 64'(price_o), 64'(e.price));
                chk("shares", 64'(shares_o), 64'(e.shares));
                chk("buysell", 64'(bs_o), 64'(e.bs));
                chk("msg_count_at_pulse", 64'(msgc_o), 64'(n_pop));
            end
        end
    end

    initial begin
        msg_t m;
        int   len_err;
        logic [2:0] long_e, long_a;
`ifdef LEN_CHECK_EN
        len_err = 1; long_e = 3'b000; long_a = 3'b000;
`else
        len_err = 0; long_e = 3'b001; long_a = 3'b100;
`endif
        rstn = 1'b0; dv = 1'b0; dl = 1'b0; din = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rstn = 1'b1;

        tbl[0] = mk(8'h41, 16'd36, 16'h0007, 64'h1234, 32'd100, 32'h0001_86A0, 8'h42, 3'b100, 0);
        tbl[1] = mk(8'h45, 16'd31, 16'h0007, 64'h1234, 32'd40, 32'd0, 8'h00, 3'b001, 0);
        tbl[2] = mk(8'h44, 16'd19, 16'h0007, 64'h1234, 32'd0, 32'd0, 8'h00, 3'b010, 0);
        tbl[3] = mk(8'h53, 16'd12, 16'h0003, 64'h0, 32'd0, 32'd0, 8'h00, 3'b000, 0);
        tbl[4] = mk(8'h44, 16'd19, 16'hBEEF, 64'hFEDC_BA98_7654_3210, 32'd0, 32'd0, 8'h00, 3'b010, 0);
        tbl[5] = mk(8'h41, 16'd36, 16'hFFFF, 64'hFFFF_0000_FFFF_0001, 32'hFFFF_FFFF, 32'h7FFF_FFFF,
                    8'h53, 3'b100, 0);
        tbl[6] = mk(8'h00, 16'd0, 16'h0, 64'h0, 32'd0, 32'd0, 8'h00, 3'b000, 0);
        tbl[7] = mk(8'h45, 16'd40, 16'h0102, 64'h0A0B_0C0D_0E0F_1011, 32'h0000_BEEF, 32'd0, 8'h00,
                    long_e, len_err);
        tbl[8] = mk(8'h41, 16'd40, 16'h0304, 64'h0000_0000_0000_0042, 32'd7, 32'h1234_5678, 8'h42,
                    long_a, len_err);
        tbl[9] = mk(8'h58, 16'd1, 16'h0, 64'h0, 32'd0, 32'd0, 8'h00, 3'b000, 0);

        // A, E, D back-to-back in one payload
        send_hdr();
        for (int i = 0; i <= 2; i++) send_msg(tbl[i], i == 2, -1);
        settle();

        // unsupported 'S' skipped, then a D
        send_hdr();
        for (int i = 3; i <= 4; i++) send_msg(tbl[i], i == 4, -1);
        settle();

        // mixed table payload with idle gaps: sell-side A, zero-length block, long E/A, 1-byte unknown
        idle_en = 1'b1;
        send_hdr();
        for (int i = 5; i <= 9; i++) send_msg(tbl[i], 1'b0, -1);
        send_msg(tbl[2], 1'b1, -1);
        settle();
        idle_en = 1'b0;

        // A truncated by dataLastIn at body byte 20, then a clean A in the next payload
        send_hdr();
        send_msg(tbl[0], 1'b0, 20);
        settle();
        send_hdr();
        send_msg(tbl[0], 1'b1, -1);
        settle();

        // D with an oversize block
        m = mk(8'h44, 16'd20, 16'h0099, 64'h1122_3344_5566_7788, 32'd0, 32'd0, 8'h00,
               (len_err != 0) ? 3'b000 : 3'b010, len_err);
        send_hdr();
        send_msg(m, 1'b1, -1);
        settle();

        // reset held three cycles in the middle of a message
        send_hdr();
        drive_byte(8'h00, 1'b0);
        drive_byte(8'h24, 1'b0);
        for (int k = 0; k < 10; k++) drive_byte(msg_byte(tbl[0], k), 1'b0);
        rstn = 1'b0;
        dv = 1'b1; din = 8'h41;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("midrst");
        q.delete();
        n_push = 0; n_pop = 0; exp_err = 0;
        dv = 1'b0;
        rstn = 1'b1;
        send_hdr();
        for (int i = 0; i <= 2; i++) send_msg(tbl[i], i == 2, -1);
        settle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, expected completion before 2000000");
        $fatal(1);
    end

endmodule
